ttc_cmd_decoder: RTL and testbench
==================================

TTC_CMD_DECODER -- requirements
Module: ttc_cmd_decoder

Interface
REQ-001 SHALL have parameter MXCNT, default 32, width of the event and error counters.
REQ-002 SHALL have parameter MXCAL, default 8, width of the calpulse delay and width fields.
REQ-003 SHALL have port clock  input  1  the 40 MHz TTC clock; the only clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port ttc_cmd  input  8  command byte, one per clock: b0 L1A, b1 BC0, b2 EC0, b3 resync, b4 OC0, b5 calpulse, b6 hard_reset, b7 reserved.
REQ-006 SHALL have port cmd_mask  input  8  per-bit enable; a 0 in a bit blocks that command.
REQ-007 SHALL have port cal_delay  input  MXCAL  cycles from calpulse command to pulse start.
REQ-008 SHALL have port cal_width  input  MXCAL  pulse length in cycles; 0 is treated as 1.
REQ-009 SHALL have outputs ttc_l1a, ttc_bx0, ttc_ec0, ttc_resync, ttc_oc0 and ttc_hard_reset  output  1 each  decoded strobes.
REQ-010 SHALL have port ttc_calpulse  output  1  delayed calibration pulse.
REQ-011 SHALL have port l1a_counter  output  MXCNT  event counter.
REQ-012 SHALL have ports cal_drop_cnt and cmd_err_cnt  output  MXCNT each  counts of dropped calpulses and illegal command bytes.

Function
REQ-013 Each decoded strobe SHALL be a registered copy of (ttc_cmd[i] & cmd_mask[i]), so latency is exactly 1 clock and width equals the input width.
REQ-014 A byte with b7=1, or with both b3 and b6 set, SHALL be illegal.
REQ-015 An illegal byte SHALL suppress all strobes for that cycle and increment cmd_err_cnt, regardless of cmd_mask.
REQ-016 l1a_counter SHALL increment by 1 on each forwarded L1A and wrap from all-ones to 0.
REQ-017 l1a_counter SHALL clear on a forwarded EC0 or resync.
REQ-018 If an L1A is forwarded in the same cycle as EC0 or resync, l1a_counter SHALL become 1.
REQ-019 The calpulse FSM SHALL have states IDLE, DELAY and PULSE.
REQ-020 In IDLE, a forwarded calpulse SHALL load the delay counter with cal_delay and move to DELAY; if cal_delay=0, the FSM SHALL go directly to PULSE.
REQ-021 DELAY SHALL count down to 0 and then enter PULSE, so ttc_calpulse first rises cal_delay+1 clocks after the command cycle.
REQ-022 In PULSE, ttc_calpulse SHALL be high for max(cal_width,1) cycles, then the FSM SHALL return to IDLE.
REQ-023 cal_delay and cal_width SHALL be latched when the calpulse command is accepted; later changes SHALL NOT affect a pulse in flight.
REQ-024 A forwarded calpulse arriving in DELAY or PULSE SHALL be ignored and increment cal_drop_cnt.
REQ-025 A forwarded resync or hard_reset in any FSM state SHALL force IDLE next cycle and deassert ttc_calpulse; a calpulse in that same cycle SHALL be discarded without counting.
REQ-026 cmd_err_cnt and cal_drop_cnt SHALL saturate at all-ones and clear on a forwarded resync.
REQ-027 l1a_counter SHALL NOT saturate.

Reset
REQ-028 While reset=0 at a clock edge, all strobes, ttc_calpulse and all counters SHALL be 0 and the FSM SHALL be IDLE.
REQ-029 A command present in the cycle reset is released SHALL still be decoded normally.
REQ-030 Reset asserted mid-DELAY or mid-PULSE SHALL abort the pulse with no residual output.

Structure
REQ-031 The command bit positions, the MXCNT and MXCAL defaults, and the FSM state encoding SHALL reside in the shared TTC package used by ttc and this block.
REQ-032 The calpulse FSM SHALL be a sub-module named ttc_calpulse_gen.
REQ-033 The ttc_bx0 and ttc_resync outputs SHALL connect directly to the downstream ttc block inputs.

Verification
REQ-034 Send ttc_cmd=0x01 ×3 with mask 0xFF -> ttc_l1a high for 3 cycles starting 1 clock later; l1a_counter=3.
REQ-035 Send 0x05 (L1A+EC0) with l1a_counter=7 -> l1a_counter=1 and ttc_ec0 pulses once.
REQ-036 cal_delay=4, cal_width=2, send 0x20 at cycle T -> ttc_calpulse high at T+5 and T+6 only; a second 0x20 at T+2 -> cal_drop_cnt=1.
REQ-037 Send 0x20, then 0x08 at T+2 -> no calpulse output, FSM returns to IDLE, and all counters clear.
REQ-038 Send 0x80 and 0x48 -> no strobes and cmd_err_cnt=2; send 0x02 with cmd_mask=0xFD -> ttc_bx0 stays 0.
REQ-039 Set reset=0 at T+3 with cal_delay=2 after 0x20 at T -> ttc_calpulse never asserts and counters read 0.

Source files
------------

// File: rtl/ttc_cmd_decoder_pkg.sv
// Shared TTC definitions: command bit positions, default widths and the
// calibration-pulse FSM state encoding.
package ttc_cmd_decoder_pkg;

    localparam int MXCNT_DEF = 32;
    localparam int MXCAL_DEF = 8;

    localparam int CMD_L1A        = 0;
    localparam int CMD_BC0        = 1;
    localparam int CMD_EC0        = 2;
    localparam int CMD_RESYNC     = 3;
    localparam int CMD_OC0        = 4;
    localparam int CMD_CALPULSE   = 5;
    localparam int CMD_HARD_RESET = 6;
    localparam int CMD_RSVD       = 7;

    typedef enum logic [1:0] {
        CAL_IDLE  = 2'd0,
        CAL_DELAY = 2'd1,
        CAL_PULSE = 2'd2
    } cal_state_t;

    // Reserved bit set, or resync together with hard_reset, is not a valid command.
    function automatic logic cmd_illegal(input logic [7:0] cmd);
        return cmd[CMD_RSVD] | (cmd[CMD_RESYNC] & cmd[CMD_HARD_RESET]);
    endfunction

endpackage

// File: rtl/ttc_cmd_decoder_if.sv
// Command-side bus into the decoder: the raw TTC byte, its enable mask and
// the calibration pulse timing settings.
interface ttc_cmd_if
    import ttc_cmd_decoder_pkg::*;
#(
    parameter int MXCAL = MXCAL_DEF
);
    logic [7:0]       ttc_cmd;
    logic [7:0]       cmd_mask;
    logic [MXCAL-1:0] cal_delay;
    logic [MXCAL-1:0] cal_width;

    modport master (
        output ttc_cmd,
        output cmd_mask,
        output cal_delay,
        output cal_width
    );

    modport slave (
        input ttc_cmd,
        input cmd_mask,
        input cal_delay,
        input cal_width
    );
endinterface

// File: rtl/ttc_cmd_decoder_calpulse_gen.sv
// Calibration pulse generator: delays an accepted calpulse command, emits a
// pulse of programmable width and counts calpulses dropped while busy.
module ttc_calpulse_gen
    import ttc_cmd_decoder_pkg::*;
#(
    parameter int MXCNT = MXCNT_DEF,
    parameter int MXCAL = MXCAL_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cal_cmd,
    input  logic             abort,
    input  logic             clear_cnt,
    input  logic [MXCAL-1:0] cal_delay,
    input  logic [MXCAL-1:0] cal_width,
    output logic             ttc_calpulse,
    output logic [MXCNT-1:0] cal_drop_cnt
);

    localparam logic [MXCAL-1:0] CAL_ONE = {{(MXCAL-1){1'b0}}, 1'b1};
    localparam logic [MXCNT-1:0] CNT_ONE = {{(MXCNT-1){1'b0}}, 1'b1};

    cal_state_t       state;
    logic [MXCAL-1:0] dly_cnt;
    logic [MXCAL-1:0] wid_cnt;
    logic [MXCAL-1:0] wid_lat;

    function automatic logic [MXCAL-1:0] width_eff(input logic [MXCAL-1:0] w);
        return (w == '0) ? CAL_ONE : w;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= CAL_IDLE;
            ttc_calpulse <= 1'b0;
            dly_cnt      <= '0;
            wid_cnt      <= '0;
            wid_lat      <= '0;
            cal_drop_cnt <= '0;
        end else begin
            // abort implies no counting, so a calpulse alongside resync/hard_reset is silently lost
            if (clear_cnt) begin
                cal_drop_cnt <= '0;
            end else if (cal_cmd && !abort && state != CAL_IDLE && cal_drop_cnt != '1) begin
                cal_drop_cnt <= cal_drop_cnt + CNT_ONE;
            end

            if (abort) begin
                state        <= CAL_IDLE;
                ttc_calpulse <= 1'b0;
            end else begin
                case (state)
                    CAL_IDLE: begin
                        if (cal_cmd) begin
                            wid_lat <= width_eff(cal_width);
                            if (cal_delay == '0) begin
                                state        <= CAL_PULSE;
                                ttc_calpulse <= 1'b1;
                                wid_cnt      <= width_eff(cal_width);
                            end else begin
                                state   <= CAL_DELAY;
                                dly_cnt <= cal_delay;
                            end
                        end
                    end
                    CAL_DELAY: begin
                        if (dly_cnt == CAL_ONE) begin
                            state        <= CAL_PULSE;
                            ttc_calpulse <= 1'b1;
                            wid_cnt      <= wid_lat;
                        end else begin
                            dly_cnt <= dly_cnt - CAL_ONE;
                        end
                    end
                    CAL_PULSE: begin
                        if (wid_cnt == CAL_ONE) begin
                            state        <= CAL_IDLE;
                            ttc_calpulse <= 1'b0;
                        end else begin
                            wid_cnt <= wid_cnt - CAL_ONE;
                        end
                    end
                    default: begin
                        state        <= CAL_IDLE;
                        ttc_calpulse <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/ttc_cmd_decoder.sv
// TTC command byte decoder: masks and validates each command byte, registers
// the decoded strobes and maintains the L1A and error counters.
module ttc_cmd_decoder
    import ttc_cmd_decoder_pkg::*;
#(
    parameter int MXCNT = MXCNT_DEF,
    parameter int MXCAL = MXCAL_DEF
) (
    input  logic             clock,
    input  logic             reset,
    ttc_cmd_if.slave         cmd_bus,
    output logic             ttc_l1a,
    output logic             ttc_bx0,
    output logic             ttc_ec0,
    output logic             ttc_resync,
    output logic             ttc_oc0,
    output logic             ttc_hard_reset,
    output logic             ttc_calpulse,
    output logic [MXCNT-1:0] l1a_counter,
    output logic [MXCNT-1:0] cal_drop_cnt,
    output logic [MXCNT-1:0] cmd_err_cnt
);

    localparam logic [MXCNT-1:0] CNT_ONE = {{(MXCNT-1){1'b0}}, 1'b1};

    logic       illegal;
    logic [7:0] fwd;
    logic       unused_rsvd;

    assign illegal     = cmd_illegal(cmd_bus.ttc_cmd);
    assign fwd         = illegal ? 8'h00 : (cmd_bus.ttc_cmd & cmd_bus.cmd_mask);
    assign unused_rsvd = fwd[CMD_RSVD];

    always_ff @(posedge clock) begin
        if (!reset) begin
            ttc_l1a        <= 1'b0;
            ttc_bx0        <= 1'b0;
            ttc_ec0        <= 1'b0;
            ttc_resync     <= 1'b0;
            ttc_oc0        <= 1'b0;
            ttc_hard_reset <= 1'b0;
            l1a_counter    <= '0;
            cmd_err_cnt    <= '0;
        end else begin
            ttc_l1a        <= fwd[CMD_L1A];
            ttc_bx0        <= fwd[CMD_BC0];
            ttc_ec0        <= fwd[CMD_EC0];
            ttc_resync     <= fwd[CMD_RESYNC];
            ttc_oc0        <= fwd[CMD_OC0];
            ttc_hard_reset <= fwd[CMD_HARD_RESET];

            // an L1A coincident with a clear is the first event of the new count
            if (fwd[CMD_EC0] || fwd[CMD_RESYNC]) begin
                l1a_counter <= fwd[CMD_L1A] ? CNT_ONE : '0;
            end else if (fwd[CMD_L1A]) begin
                l1a_counter <= l1a_counter + CNT_ONE;
            end

            if (fwd[CMD_RESYNC]) begin
                cmd_err_cnt <= '0;
            end else if (illegal && cmd_err_cnt != '1) begin
                cmd_err_cnt <= cmd_err_cnt + CNT_ONE;
            end
        end
    end

    ttc_calpulse_gen #(
        .MXCNT (MXCNT),
        .MXCAL (MXCAL)
    ) u_calpulse_gen (
        .clock        (clock),
        .reset        (reset),
        .cal_cmd      (fwd[CMD_CALPULSE]),
        .abort        (fwd[CMD_RESYNC] | fwd[CMD_HARD_RESET]),
        .clear_cnt    (fwd[CMD_RESYNC]),
        .cal_delay    (cmd_bus.cal_delay),
        .cal_width    (cmd_bus.cal_width),
        .ttc_calpulse (ttc_calpulse),
        .cal_drop_cnt (cal_drop_cnt)
    );

endmodule

// File: tb/tb_ttc_cmd_decoder.sv
// Bench for ttc_cmd_decoder: directed scenarios plus randomized command
// traffic, every cycle compared against a cycle-indexed behavioural model.
module tb_ttc_cmd_decoder;
    localparam int MXCNT   = 6;
    localparam int MXCAL   = 8;
    localparam int CNT_MAX = (1 << MXCNT) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             ttc_l1a, ttc_bx0, ttc_ec0, ttc_resync, ttc_oc0, ttc_hard_reset;
    logic             ttc_calpulse;
    logic [MXCNT-1:0] l1a_counter, cal_drop_cnt, cmd_err_cnt;

    ttc_cmd_if #(.MXCAL(MXCAL)) bus ();

    ttc_cmd_decoder #(.MXCNT(MXCNT), .MXCAL(MXCAL)) dut (
        .clock          (clock),
        .reset          (reset),
        .cmd_bus        (bus),
        .ttc_l1a        (ttc_l1a),
        .ttc_bx0        (ttc_bx0),
        .ttc_ec0        (ttc_ec0),
        .ttc_resync     (ttc_resync),
        .ttc_oc0        (ttc_oc0),
        .ttc_hard_reset (ttc_hard_reset),
        .ttc_calpulse   (ttc_calpulse),
        .l1a_counter    (l1a_counter),
        .cal_drop_cnt   (cal_drop_cnt),
        .cmd_err_cnt    (cmd_err_cnt)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: cycle index of each sampling edge, and the accepted calpulse window.
    int       ncyc = 0;
    int       exp_l1a = 0, exp_err = 0, exp_drop = 0;
    logic [5:0] exp_strb = '0;
    logic     exp_cal = 1'b0;
    logic     cal_on = 1'b0;
    int       cal_t0 = 0, cal_d = 0, cal_w = 0;
    logic     saw_cal = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, ncyc, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [7:0] cmd, input logic [7:0] m,
                              input int d, input int w);
        logic [7:0] f;
        logic bad, busy;
        ncyc++;
        if (!r) begin
            exp_strb = '0; exp_l1a = 0; exp_err = 0; exp_drop = 0;
            cal_on = 1'b0; exp_cal = 1'b0;
        end else begin
            bad = cmd[7] || (cmd[3] && cmd[6]);
            f = bad ? 8'h00 : (cmd & m);
            exp_strb = {f[6], f[4], f[3], f[2], f[1], f[0]};
            if (bad && exp_err < CNT_MAX) exp_err++;
            if (f[3]) begin exp_err = 0; exp_drop = 0; end
            if (f[2] || f[3]) exp_l1a = f[0] ? 1 : 0;
            else if (f[0]) exp_l1a = (exp_l1a + 1) % (CNT_MAX + 1);
            busy = cal_on && (ncyc <= cal_t0 + cal_d + cal_w);
            if (f[3] || f[6]) cal_on = 1'b0;
            else if (f[5]) begin
                if (busy) begin
                    if (exp_drop < CNT_MAX) exp_drop++;
                end else begin
                    cal_on = 1'b1; cal_t0 = ncyc; cal_d = d; cal_w = (w == 0) ? 1 : w;
                end
            end
            exp_cal = cal_on && (ncyc >= cal_t0 + cal_d) && (ncyc <= cal_t0 + cal_d + cal_w - 1);
        end
    endtask

    task automatic step(input logic [7:0] cmd);
        logic [7:0] m;
        int d, w;
        logic r;
        bus.ttc_cmd = cmd;
        m = bus.cmd_mask;
        d = int'(bus.cal_delay);
        w = int'(bus.cal_width);
        r = reset;
        @(posedge clock);
        model_edge(r, cmd, m, d, w);
        #1;
        check_val("strobes", 64'({ttc_hard_reset, ttc_oc0, ttc_resync, ttc_ec0, ttc_bx0, ttc_l1a}), 64'(exp_strb));
        check_val("calpulse", 64'(ttc_calpulse), 64'(exp_cal));
        check_val("l1a_counter", 64'(l1a_counter), 64'(exp_l1a));
        check_val("cmd_err_cnt", 64'(cmd_err_cnt), 64'(exp_err));
        check_val("cal_drop_cnt", 64'(cal_drop_cnt), 64'(exp_drop));
        if (ttc_calpulse) saw_cal = 1'b1;
    endtask

    initial begin
        logic [8:0] pat;
        logic [7:0] c;
        int prob[8] = '{40, 10, 3, 2, 5, 8, 2, 2};

        bus.ttc_cmd   = 8'h00;
        bus.cmd_mask  = 8'hFF;
        bus.cal_delay = 8'd4;
        bus.cal_width = 8'd2;

        // Reset holds everything at zero even with commands present
        repeat (3) step(8'h21);
        check_val("rst_cnt", 64'(l1a_counter), 64'd0);

        // Command in the release cycle is decoded
        reset = 1'b1;
        step(8'h02);
        check_val("rel_bx0", 64'(ttc_bx0), 64'd1);

        // Three L1As
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            step((i < 3) ? 8'h01 : 8'h00);
            pat[i] = ttc_l1a;
        end
        check_val("l1a_pat", 64'(pat[3:0]), 64'b0111);
        check_val("l1a_cnt3", 64'(l1a_counter), 64'd3);

        // L1A with EC0
        repeat (4) step(8'h01);
        check_val("l1a_cnt7", 64'(l1a_counter), 64'd7);
        step(8'h05);
        check_val("ec0_l1a_cnt", 64'(l1a_counter), 64'd1);
        check_val("ec0_strobe", 64'(ttc_ec0), 64'd1);
        step(8'h00);
        check_val("ec0_once", 64'(ttc_ec0), 64'd0);

        // Delayed calpulse with a dropped second request
        pat = '0;
        for (int i = 0; i < 9; i++) begin
            step((i == 0 || i == 2) ? 8'h20 : 8'h00);
            if (i == 0) begin bus.cal_delay = 8'd1; bus.cal_width = 8'd7; end
            pat[i] = ttc_calpulse;
        end
        check_val("cal_pat", 64'(pat), 64'b000110000);
        check_val("cal_drop1", 64'(cal_drop_cnt), 64'd1);

        // Resync aborts a pending pulse and clears counters
        bus.cal_delay = 8'd4; bus.cal_width = 8'd2;
        step(8'h80);
        saw_cal = 1'b0;
        step(8'h20); step(8'h00); step(8'h08);
        repeat (8) step(8'h00);
        check_val("resync_nocal", 64'(saw_cal), 64'd0);
        check_val("resync_err", 64'(cmd_err_cnt), 64'd0);
        check_val("resync_drop", 64'(cal_drop_cnt), 64'd0);
        check_val("resync_l1a", 64'(l1a_counter), 64'd0);

        // Illegal bytes and masking
        step(8'h80); step(8'h48);
        check_val("err2", 64'(cmd_err_cnt), 64'd2);
        bus.cmd_mask = 8'hFD;
        step(8'h02);
        check_val("masked_bx0", 64'(ttc_bx0), 64'd0);
        bus.cmd_mask = 8'hFF;

        // Calpulse alongside resync while busy is not counted
        step(8'h20); step(8'h28); step(8'h00);

        // Reset during DELAY leaves no pulse
        bus.cal_delay = 8'd2; bus.cal_width = 8'd3;
        saw_cal = 1'b0;
        step(8'h20); step(8'h00);
        reset = 1'b0;
        step(8'h00); step(8'h00);
        check_val("rst_mid_cnt", 64'(cal_drop_cnt | cmd_err_cnt | l1a_counter), 64'd0);
        reset = 1'b1;
        repeat (6) step(8'h00);
        check_val("rst_mid_nocal", 64'(saw_cal), 64'd0);

        // Wrap and saturation
        repeat (70) step(8'h01);
        repeat (70) step(8'h80);
        check_val("err_sat", 64'(cmd_err_cnt), 64'(CNT_MAX));
        bus.cal_delay = 8'd200;
        repeat (71) step(8'h20);
        check_val("drop_sat", 64'(cal_drop_cnt), 64'(CNT_MAX));
        step(8'h40);
        check_val("hr_keeps_drop", 64'(cal_drop_cnt), 64'(CNT_MAX));
        step(8'h08);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            c = '0;
            for (int b = 0; b < 8; b++) c[b] = ($urandom_range(0, 99) < prob[b]);
            bus.cmd_mask  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hFF;
            bus.cal_delay = 8'($urandom_range(0, 6));
            bus.cal_width = 8'($urandom_range(0, 4));
            reset = ($urandom_range(0, 199) != 0);
            step(c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
